// File: rtl/seq_ctrl_pkg.sv
// Shared definitions for the frame-level sequence-scan controller.
// Contents:
//   - state encoding (3-bit) for the controller FSM, as an enum for debug
//     viewing and as plain localparam constants for the RTL
//   - cw_of(): width of a counter able to hold the values 0..width
package seq_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_SHIFT = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    localparam logic [2:0] ST_IDLE  = S_IDLE;
    localparam logic [2:0] ST_CLEAR = S_CLEAR;
    localparam logic [2:0] ST_SHIFT = S_SHIFT;
    localparam logic [2:0] ST_DRAIN = S_DRAIN;
    localparam logic [2:0] ST_DONE  = S_DONE;

    function automatic int cw_of(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// Frame/result bus between a parallel producer/consumer and seq_scan_ctrl.
// Signals:
//   frame_valid/frame_ready/frame_data : frame channel (producer -> controller)
//   result_valid/result_ready          : result channel (controller -> consumer)
//   hit_mask/hit_count                 : result payload
//   busy                               : controller is not in IDLE
// Handshake rule for both channels: a transfer happens on a rising clock edge
// where valid && ready; once valid is raised it stays up, with payload stable,
// until that transfer. Ready may be asserted independently of valid.
interface seq_scan_ctrl_if
    import seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
);
    localparam int CW = cw_of(WIDTH);

    logic             frame_valid;
    logic             frame_ready;
    logic [WIDTH-1:0] frame_data;
    logic             result_valid;
    logic             result_ready;
    logic [WIDTH-1:0] hit_mask;
    logic [CW-1:0]    hit_count;
    logic             busy;

    // Producer/consumer side.
    modport master (
        output frame_valid, frame_data, result_ready,
        input  frame_ready, result_valid, hit_mask, hit_count, busy
    );

    // Controller side.
    modport slave (
        input  frame_valid, frame_data, result_ready,
        output frame_ready, result_valid, hit_mask, hit_count, busy
    );

endinterface

// File: rtl/seq_frame_ser.sv
// Frame serializer: WIDTH-bit load/shift-left register with a down-counting
// bit index.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load_i     : capture data_i, index set to WIDTH (one above the MSB)
//   data_i     : frame to serialize
//   shift_i    : emit bit_o this cycle; register shifts left, index decrements
//   bit_o      : next bit to present (register MSB)
//   idx_o      : index of the bit most recently emitted
//   last_o     : bit 0 has been emitted (idx_o == 0)
module seq_frame_ser
    import seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CW = cw_of(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             shift_i,
    output logic             bit_o,
    output logic [CW-1:0]    idx_o,
    output logic             last_o
);

    logic [WIDTH-1:0] sh_q;
    logic [CW-1:0]    idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q  <= '0;
            idx_q <= '0;
        end else if (load_i) begin
            sh_q  <= data_i;
            idx_q <= CW'(WIDTH);
        end else if (shift_i) begin
            sh_q  <= {sh_q[WIDTH-2:0], 1'b0};
            idx_q <= idx_q - 1'b1;
        end
    end

    assign bit_o  = sh_q[WIDTH-1];
    assign idx_o  = idx_q;
    assign last_o = (idx_q == '0);

endmodule

// File: rtl/seq_scan_ctrl.sv
// Frame-level controller for the serial sequence detector. Accepts a frame,
// clears the detector for one cycle, streams the frame MSB-first, samples
// the detector output after every bit and returns a hit mask and count.
// Ports:
//   clk, reset : clock, asynchronous active-low reset
//   bus        : frame/result handshakes and result payload (slave side)
//   det_rst_n  : registered active-low clear to the detector
//   det_in     : registered serial bit to the detector
//   det_out    : detector Moore output (reflects the bit consumed last edge)
//   dbg_state  : current FSM state
module seq_scan_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CW = cw_of(WIDTH)
) (
    input  logic           clk,
    input  logic           reset,
    seq_scan_ctrl_if.slave bus,
    output logic           det_rst_n,
    output logic           det_in,
    input  logic           det_out,
    output logic [2:0]     dbg_state
);

    logic [2:0]       state_q, state_d;
    logic             det_rst_n_q, det_rst_n_d;
    logic             det_in_q, det_in_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             load;
    logic             shift;
    logic             sample;
    logic             ser_bit;
    logic [CW-1:0]    ser_idx;
    logic             ser_last;

    seq_frame_ser #(.WIDTH(WIDTH)) u_ser (
        .clk     (clk),
        .rst_n   (reset),
        .load_i  (load),
        .data_i  (bus.frame_data),
        .shift_i (shift),
        .bit_o   (ser_bit),
        .idx_o   (ser_idx),
        .last_o  (ser_last)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            ST_IDLE:  if (bus.frame_valid) begin
                          state_d = ST_CLEAR;
                          load    = 1'b1;
                      end
            ST_CLEAR: begin
                          state_d = ST_SHIFT;
                          shift   = 1'b1;
                      end
            ST_SHIFT: if (ser_last) state_d = ST_DRAIN;
                      else          shift   = 1'b1;
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  if (bus.result_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // The detector pins are registered, so they are derived from the state
    // being entered: a bit is driven exactly in the cycles spent in SHIFT.
    always_comb begin
        det_in_d    = shift ? ser_bit : 1'b0;
        det_rst_n_d = (state_d != ST_CLEAR);
    end

    // det_out lags the bit it describes by one cycle. The first SHIFT cycle
    // still sees the cleared detector, and DRAIN picks up bit 0. Bits arrive
    // MSB-first, so shifting them in from the LSB lands each at its index
    // after WIDTH samples.
    always_comb begin
        sample = ((state_q == ST_SHIFT) && (ser_idx != CW'(WIDTH - 1)))
              || (state_q == ST_DRAIN);
        mask_d = mask_q;
        cnt_d  = cnt_q;
        if (load) begin
            mask_d = '0;
            cnt_d  = '0;
        end else if (sample) begin
            mask_d = {mask_q[WIDTH-2:0], det_out};
            cnt_d  = cnt_q + CW'(det_out);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            det_rst_n_q <= 1'b0;
            det_in_q    <= 1'b0;
            mask_q      <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            det_rst_n_q <= det_rst_n_d;
            det_in_q    <= det_in_d;
            mask_q      <= mask_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.frame_ready  = (state_q == ST_IDLE);
    assign bus.result_valid = (state_q == ST_DONE);
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.hit_mask     = mask_q;
    assign bus.hit_count    = cnt_q;
    assign det_rst_n        = det_rst_n_q;
    assign det_in           = det_in_q;
    assign dbg_state        = state_q;

endmodule

// File: doc/seq_scan_ctrl.md
# seq_scan_ctrl

Frame-level controller for the serial sequence detector (`seq`). It accepts parallel frames over a valid/ready handshake and clears the detector before each frame. It then streams the frame MSB-first into the detector, samples the detector's `out` after every bit, and returns a per-bit hit mask and a hit count over a second valid/ready handshake. It sits between a parallel producer and the bit-serial detector, so software-side logic never drives the detector's `in` directly.

## Interface
Parameters:
- `WIDTH`, 8: bits per frame (≥2).
- `CW`, `$clog2(WIDTH+1)`: hit-count width (derived, not overridden).

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `frame_valid`  in  1: producer has a frame.
- `frame_ready`  out  1: controller can accept a frame.
- `frame_data`  in  WIDTH: frame; bit `WIDTH-1` is sent first.
- `det_rst_n`  out  1: registered active-low clear to detector `reset`.
- `det_in`  out  1: registered serial bit to detector `in`.
- `det_out`  in  1: detector `out`, a Moore output valid the cycle after a bit is consumed.
- `result_valid`  out  1: result available.
- `result_ready`  in  1: consumer takes result.
- `hit_mask`  out  WIDTH: bit k = 1 if the detector fired after consuming `frame_data[k]`.
- `hit_count`  out  CW: popcount of `hit_mask`.
- `busy`  out  1: high in every state except IDLE.

## Operation
- States: IDLE, CLEAR, SHIFT, DRAIN, DONE.
- IDLE:
  - `frame_ready`=1.
  - On `frame_valid`&&`frame_ready`, latch `frame_data` into the shift register, clear mask and count, and go to CLEAR.
- CLEAR (1 cycle):
  - `det_rst_n`=0 and `det_in`=0.
  - Go to SHIFT with bit index = `WIDTH-1`.
- SHIFT (WIDTH cycles):
  - `det_rst_n`=1 and `det_in` = current bit, MSB-first.
  - In every SHIFT cycle after the first, sample `det_out` into `hit_mask[index+1]`, and increment the count if set.
  - Leave after index 0 is presented; go to DRAIN.
- DRAIN (1 cycle):
  - `det_in`=0.
  - Sample `det_out` into `hit_mask[0]` and go to DONE.
- DONE:
  - `result_valid`=1, with `hit_mask`/`hit_count` stable.
  - On `result_ready`, go to IDLE.
- `frame_ready` is low in all states except IDLE; there is no input skid buffer.
- Outside SHIFT, `det_in`=0. Outside CLEAR, `det_rst_n`=1.
- The count saturates naturally: its maximum is WIDTH, which always fits in CW.

## Timing
- Reset values:
  - State IDLE.
  - `frame_ready`=1 (combinational from state, so it reads 1 while reset is held).
  - `det_rst_n`=0 while reset is asserted; it is registered 1 after release.
  - `det_in`=0, `result_valid`=0, `hit_mask`=0, `hit_count`=0, `busy`=0.
- Latency: accept edge at cycle 0, CLEAR in cycle 1, SHIFT in cycles 2..WIDTH+1, DRAIN in cycle WIDTH+2, and `result_valid` from cycle WIDTH+3. That is WIDTH+3 cycles from accept to result.
- Throughput: one frame per WIDTH+4 cycles when `result_ready` is held high. The DONE→IDLE cycle is mandatory.
- Handshakes:
  - A transfer occurs on a rising edge with valid&&ready.
  - `result_valid` never drops without `result_ready`.
  - `frame_data` is ignored except on the accept edge.
- Backpressure: in DONE with `result_ready`=0, the controller holds indefinitely with outputs stable. The detector idles on `det_in`=0.
- Reset mid-frame: everything returns to reset values immediately. No partial result is emitted. The next frame starts with a fresh CLEAR.
- `frame_valid` asserted while busy is not accepted and is not lost from the producer's view, since ready is low.

## Structure
- Package `seq_ctrl_pkg`: state enum (3-bit encoding) and the `CW` derivation function.
- One natural sub-module, `seq_frame_ser`: a WIDTH-bit load/shift-left register plus down-counter index with a `last` flag. The FSM, the capture of `hit_mask`/`hit_count`, and the handshakes stay in `seq_scan_ctrl`.
- The detector `seq` is instantiated by the parent, not inside this block.

## Test plan
The bench uses a Moore stub detector that fires when the last three consumed bits are 111 and clears on `det_rst_n`=0. WIDTH=8.
- Frame 8'b0111_0010, `result_ready`=1 → `hit_mask`=8'b0001_0000, `hit_count`=1. `result_valid` rises exactly 11 cycles after accept.
- Frame 8'hFF, then frame 8'hFF back-to-back → both results are mask 8'h3F, count 6. This proves CLEAR isolates frames. Accepts are 12 cycles apart.
- Frame 8'h00 → mask 8'h00, count 0. `det_in` stays 0 throughout and `det_rst_n` pulses low for exactly one cycle.
- Frame 8'hFF with `result_ready` held 0 for 20 cycles → `result_valid`, mask 8'h3F and count 6 stay stable. `frame_ready`=0 and a second `frame_valid` is not accepted until one cycle after `result_ready`.
- Reset pulled low during SHIFT bit 4 of 8'hFF → all outputs return to reset values asynchronously. No `result_valid` appears. A following frame 8'b0111_0010 yields mask 8'b0001_0000.
